alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_op_decode.sv | 74 +++++++
 rtl/alu_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU issue controller:
//   - ALU Operation codes driven onto the ALU's Operation input
//   - ALUOp encodings produced by the main decoder
//   - funct3 / funct7 values that select between ALU operations
//   - controller FSM state type
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU Operation codes. The ALU returns 0 for OP_ILLEGAL.
    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_EQ      = 4'b1000;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    // ALUOp encodings from the main decoder.
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // funct3 values of interest.
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_AND = 3'b111;

    // funct7 values of interest (ALT selects SUB for R-type funct3 000).
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Combinational ALU control: maps ALUOp / funct3 / funct7 onto the ALU's
// Operation code and flags encodings the ALU cannot execute.
// Ports:
//   alu_op    in   2              ALUOp from the main decoder
//   funct3    in   3              instruction funct3
//   funct7    in   7              instruction funct7
//   operation out  OPCODE_LENGTH  ALU Operation code (OP_ILLEGAL if illegal)
//   illegal   out  1              unsupported encoding
//   is_bne    out  1              branch is BNE (EQ result must be inverted)
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [1:0]               alu_op,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    output logic [OPCODE_LENGTH-1:0] operation,
    output logic                     illegal,
    output logic                     is_bne
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path through
        // the block leaves one unassigned, which would infer a latch.
        operation = OPCODE_LENGTH'(OP_ILLEGAL);
        illegal   = 1'b1;
        is_bne    = 1'b0;

        case (alu_op)
            ALUOP_MEM: begin
                operation = OPCODE_LENGTH'(OP_ADD);
                illegal   = 1'b0;
            end
            ALUOP_BRANCH: begin
                // BEQ and BNE both use the equality compare; BNE inverts it later.
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    operation = OPCODE_LENGTH'(OP_EQ);
                    illegal   = 1'b0;
                    is_bne    = (funct3 == F3_BNE);
                end
            end
            ALUOP_RTYPE: begin
                if (funct3 == F3_ADD && funct7 == F7_BASE) begin
                    operation = OPCODE_LENGTH'(OP_ADD);
                    illegal   = 1'b0;
                end else if (funct3 == F3_ADD && funct7 == F7_ALT) begin
                    operation = OPCODE_LENGTH'(OP_SUB);
                    illegal   = 1'b0;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    operation = OPCODE_LENGTH'(OP_AND);
                    illegal   = 1'b0;
                end
            end
            ALUOP_ITYPE: begin
                // Immediate forms carry no funct7, so it is ignored here.
                if (funct3 == F3_ADD) begin
                    operation = OPCODE_LENGTH'(OP_ADD);
                    illegal   = 1'b0;
                end else if (funct3 == F3_AND) begin
                    operation = OPCODE_LENGTH'(OP_AND);
                    illegal   = 1'b0;
                end
            end
            default: begin
                operation = OPCODE_LENGTH'(OP_ILLEGAL);
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// EX-stage issue controller for a 32-bit ALU. Accepts an instruction over a
// valid/ready handshake, holds operands and Operation steady on the ALU inputs
// for one cycle, captures ALUResult and presents it with a branch decision and
// an illegal flag over an output valid/ready handshake.
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   in_valid / in_ready                upstream handshake
//   in_alu_op, in_funct3, in_funct7    decoded instruction fields
//   in_src_a, in_src_b                 operands
//   alu_src_a, alu_src_b, alu_operation  registered ALU inputs
//   alu_result                         combinational ALU output
//   out_valid / out_ready              downstream handshake
//   out_result, out_branch_taken, out_illegal  captured results
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_alu_op,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [DATA_WIDTH-1:0]    in_src_a,
    input  logic [DATA_WIDTH-1:0]    in_src_b,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_result,
    output logic                     out_branch_taken,
    output logic                     out_illegal
);

    state_t state_q, state_d;

    logic                     ready_fsm;
    logic                     accept;
    logic [OPCODE_LENGTH-1:0] dec_operation;
    logic                     dec_illegal;
    logic                     dec_is_bne;

    logic                     illegal_q;
    logic                     bne_q;
    logic                     branch_q;

    alu_op_decode #(
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_decode (
        .alu_op    (in_alu_op),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .operation (dec_operation),
        .illegal   (dec_illegal),
        .is_bne    (dec_is_bne)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ready_fsm = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                ready_fsm = 1'b1;
                if (in_valid) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Accepting the next instruction in the same cycle the result
                // is consumed keeps the pipeline at one op per two cycles.
                ready_fsm = out_ready;
                if (out_ready) state_d = in_valid ? ISSUE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset is asynchronous, so gate ready directly with rst_n to keep it low
    // for the whole time reset is held, not just from the next edge.
    assign in_ready = ready_fsm & rst_n;
    assign accept   = in_valid & in_ready;

    // -------------------------------------------------------------------------
    // Issue registers: loaded only on acceptance, held otherwise.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src_a     <= '0;
            alu_src_b     <= '0;
            alu_operation <= '0;
            illegal_q     <= 1'b0;
            bne_q         <= 1'b0;
            branch_q      <= 1'b0;
        end else if (accept) begin
            alu_src_a     <= in_src_a;
            alu_src_b     <= in_src_b;
            alu_operation <= dec_operation;
            illegal_q     <= dec_illegal;
            bne_q         <= dec_is_bne;
            branch_q      <= (in_alu_op == ALUOP_BRANCH);
        end
    end

    // -------------------------------------------------------------------------
    // Result capture at the end of ISSUE; held through DONE until consumed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result       <= '0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (state_q == ISSUE) begin
            out_result       <= illegal_q ? '0 : alu_result;
            // EQ yields 1 on equality; BNE takes the branch on the inverse.
            out_branch_taken <= (branch_q && !illegal_q) ? (alu_result[0] ^ bne_q) : 1'b0;
            out_illegal      <= illegal_q;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_alu_op;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_src_a;
    logic [31:0] in_src_b;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [3:0]  alu_operation;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_branch_taken;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_ctrl #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_alu_op        (in_alu_op),
        .in_funct3        (in_funct3),
        .in_funct7        (in_funct7),
        .in_src_a         (in_src_a),
        .in_src_b         (in_src_b),
        .alu_src_a        (alu_src_a),
        .alu_src_b        (alu_src_b),
        .alu_operation    (alu_operation),
        .alu_result       (alu_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_branch_taken (out_branch_taken),
        .out_illegal      (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU feeding the controller.
    always_comb begin
        case (alu_operation)
            4'b0000: alu_result = alu_src_a & alu_src_b;
            4'b0010: alu_result = alu_src_a + alu_src_b;
            4'b0110: alu_result = alu_src_a - alu_src_b;
            4'b1000: alu_result = (alu_src_a == alu_src_b) ? 32'd1 : 32'd0;
            default: alu_result = 32'd0;
        endcase
    end

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] res;
        logic        taken;
        logic        ill;
    } exp_t;

    exp_t        cur;
    logic [31:0] cur_a, cur_b;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: what the instruction means, computed straight from its fields.
    function automatic exp_t model(input logic [1:0] aop, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        string kind;
        kind = "bad";
        if (aop == 2'd0) kind = "add";
        else if (aop == 2'd1 && f3 == 3'd0) kind = "beq";
        else if (aop == 2'd1 && f3 == 3'd1) kind = "bne";
        else if (aop == 2'd2 && f3 == 3'd0 && f7 == 7'd0) kind = "add";
        else if (aop == 2'd2 && f3 == 3'd0 && f7 == 7'd32) kind = "sub";
        else if (aop == 2'd2 && f3 == 3'd7 && f7 == 7'd0) kind = "and";
        else if (aop == 2'd3 && f3 == 3'd0) kind = "add";
        else if (aop == 2'd3 && f3 == 3'd7) kind = "and";
        e = '0;
        case (kind)
            "add": begin e.op = 4'b0010; e.res = a + b; end
            "sub": begin e.op = 4'b0110; e.res = a - b; end
            "and": begin e.op = 4'b0000; e.res = a & b; end
            "beq": begin e.op = 4'b1000; e.res = 32'(a == b); e.taken = (a == b); end
            "bne": begin e.op = 4'b1000; e.res = 32'(a == b); e.taken = (a != b); end
            default: begin e.op = 4'b1111; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    // Called at posedge+1 with DUT in IDLE or DONE; expects acceptance next edge.
    task automatic send(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
        cur       = model(aop, f3, f7, a, b);
        cur_a     = a;
        cur_b     = b;
        in_alu_op = aop;
        in_funct3 = f3;
        in_funct7 = f7;
        in_src_a  = a;
        in_src_b  = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_ready_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_src_a = $urandom;
        in_src_b = $urandom;
        check("alu_operation", 32'(alu_operation), 32'(cur.op));
        check("alu_src_a", alu_src_a, cur_a);
        check("alu_src_b", alu_src_b, cur_b);
        check("issue_out_valid", 32'(out_valid), 32'd0);
        check("issue_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, out_result, cur.res);
        check({tag, "_taken"}, 32'(out_branch_taken), 32'(cur.taken));
        check({tag, "_illegal"}, 32'(out_illegal), 32'(cur.ill));
    endtask

    // Called in ISSUE; leaves DUT in DONE with out_ready = (stall == 0).
    task automatic receive(input int stall);
        out_ready = (stall == 0);
        @(posedge clk); #1;
        check_outputs("done");
        check("done_in_ready", 32'(in_ready), 32'(stall == 0));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_outputs("stall");
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_alu_op", 32'(alu_operation), 32'(cur.op));
        end
    endtask

    // Consume the result with nothing new offered.
    task automatic release_out();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [2:0] rand_f3();
        case ($urandom_range(0, 3))
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b111;
            default: return 3'($urandom);
        endcase
    endfunction

    function automatic logic [6:0] rand_f7();
        case ($urandom_range(0, 2))
            0: return 7'b0000000;
            1: return 7'b0100000;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 3));
            1: return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_alu_op = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_src_a  = '0;
        in_src_b  = '0;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_operation", 32'(alu_operation), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // R-type ADD 5 + 7
        send(2'b10, 3'b000, 7'b0000000, 32'd5, 32'd7);
        receive(0);
        release_out();

        // R-type SUB 3 - 5 with 5 cycles of backpressure, then back-to-back BNE
        send(2'b10, 3'b000, 7'b0100000, 32'd3, 32'd5);
        receive(5);
        send(2'b01, 3'b001, 7'b0000000, 32'd9, 32'd9);
        receive(0);
        send(2'b01, 3'b001, 7'b0000000, 32'd9, 32'd8);
        receive(2);
        release_out();

        // Illegal R-type funct3 100
        send(2'b10, 3'b100, 7'b0000000, 32'd11, 32'd22);
        receive(1);
        release_out();

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) release_out();
            send(2'($urandom), rand_f3(), rand_f7(), rand_data(), rand_data());
            receive($urandom_range(0, 3));
        end
        release_out();

        // Reset while an operation is in ISSUE
        a = 32'd100;
        send(2'b00, 3'b000, 7'b0000000, a, 32'd23);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_alu_src_a", alu_src_a, 32'd0);
        check("mid_rst_alu_operation", 32'(alu_operation), 32'd0);
        check("mid_rst_out_result", out_result, 32'd0);
        check("mid_rst_taken", 32'(out_branch_taken), 32'd0);
        check("mid_rst_illegal", 32'(out_illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_rst_in_ready", 32'(in_ready), 32'd1);
        check("after_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("after_rst_no_stale", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
